// File: rtl/nor_logic_unit.sv
// nor_logic_unit: WIDTH-bit, 4-stage valid/ready logic unit built from 2-input NOR levels.
// Ops: 0 NOT, 1 BUF, 2 NOR, 3 OR, 4 AND, 5 NAND, 6 XNOR, 7 XOR. Latency is 4 cycles for every op.
// Optional feature macro: NOR_LU_STATS_EN adds the op_count port (completed-result counter).
module nor_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op
`ifdef NOR_LU_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_BUF  = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    // The only primitive: bitwise 2-input NOR.
    function automatic logic [WIDTH-1:0] n(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return ~(x | y);
    endfunction

    logic adv;

    // Stage 1 registers: level-1 terms plus raw operands needed by level 2.
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_t, s1_na, s1_nb, s1_a, s1_b;

    // Stage 2 registers: ops finished at level 2 plus intermediates for level 3.
    logic             s2_valid;
    logic [2:0]       s2_op;
    logic [WIDTH-1:0] s2_res, s2_and, s2_u, s2_v;

    // Stage 3 registers: everything except XOR is final here.
    logic             s3_valid;
    logic [2:0]       s3_op;
    logic [WIDTH-1:0] s3_res;

    // Combinational NOR levels.
    logic [WIDTH-1:0] l1_t, l1_na, l1_nb;
    logic [WIDTH-1:0] l2_or, l2_and, l2_buf, l2_u, l2_v, l2_res;
    logic [WIDTH-1:0] l3_nand, l3_xnor, l3_res;
    logic [WIDTH-1:0] l4_res;

    // Whole pipeline moves together unless a held result is blocked downstream.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Level 1 from the input operands.
    always_comb begin
        l1_t  = n(in_a, in_b);
        l1_na = n(in_a, in_a);
        l1_nb = n(in_b, in_b);
    end

    // Level 2 and selection of ops that complete here.
    always_comb begin
        l2_or  = n(s1_t, s1_t);
        l2_and = n(s1_na, s1_nb);
        l2_buf = n(s1_na, s1_na);
        l2_u   = n(s1_a, s1_t);
        l2_v   = n(s1_b, s1_t);
        l2_res = '0;
        case (s1_op)
            OP_NOT:  l2_res = s1_na;
            OP_BUF:  l2_res = l2_buf;
            OP_NOR:  l2_res = s1_t;
            OP_OR:   l2_res = l2_or;
            OP_AND:  l2_res = l2_and;
            default: l2_res = '0;
        endcase
    end

    // Level 3: NAND and XNOR; earlier results pass through.
    always_comb begin
        l3_nand = n(s2_and, s2_and);
        l3_xnor = n(s2_u, s2_v);
        l3_res  = s2_res;
        case (s2_op)
            OP_NAND: l3_res = l3_nand;
            OP_XNOR: l3_res = l3_xnor;
            OP_XOR:  l3_res = l3_xnor;
            default: l3_res = s2_res;
        endcase
    end

    // Level 4: XOR inverts the XNOR carried from stage 3.
    always_comb begin
        l4_res = s3_res;
        if (s3_op == OP_XOR) begin
            l4_res = n(s3_res, s3_res);
        end
    end

    // Pipeline registers; all stages hold together when adv is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= 3'd0;
            s1_t      <= '0;
            s1_na     <= '0;
            s1_nb     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_valid  <= 1'b0;
            s2_op     <= 3'd0;
            s2_res    <= '0;
            s2_and    <= '0;
            s2_u      <= '0;
            s2_v      <= '0;
            s3_valid  <= 1'b0;
            s3_op     <= 3'd0;
            s3_res    <= '0;
            out_valid <= 1'b0;
            out_op    <= 3'd0;
            out_y     <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_op     <= in_op;
            s1_t      <= l1_t;
            s1_na     <= l1_na;
            s1_nb     <= l1_nb;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s2_valid  <= s1_valid;
            s2_op     <= s1_op;
            s2_res    <= l2_res;
            s2_and    <= l2_and;
            s2_u      <= l2_u;
            s2_v      <= l2_v;
            s3_valid  <= s2_valid;
            s3_op     <= s2_op;
            s3_res    <= l3_res;
            out_valid <= s3_valid;
            out_op    <= s3_op;
            out_y     <= l4_res;
        end
    end

`ifdef NOR_LU_STATS_EN
    // Completed-result counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
`else
    // Counter width only matters when statistics are built in.
    logic unused_cnt_w;
    assign unused_cnt_w = |32'(CNT_W);
`endif

endmodule

// File: tb/tb_nor_logic_unit.sv
// Directed self-checking bench for nor_logic_unit (WIDTH=8 main instance, WIDTH=1 corner instance).
// Build with NOR_LU_STATS_EN defined to also exercise the op_count wrap.
module tb_nor_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_op, out_op;
    logic [7:0] in_a, in_b, out_y;
`ifdef NOR_LU_STATS_EN
    logic [3:0] op_count;
`endif

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
    logic [2:0] w1_in_op, w1_out_op;
    logic [0:0] w1_in_a, w1_in_b, w1_out_y;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    logic [10:0] exp_q[$];

    nor_logic_unit #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op)
`ifdef NOR_LU_STATS_EN
        , .op_count(op_count)
`endif
    );

    nor_logic_unit #(.WIDTH(1), .CNT_W(4)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_op(w1_in_op), .in_a(w1_in_a), .in_b(w1_in_b),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_y(w1_out_y), .out_op(w1_out_op)
`ifdef NOR_LU_STATS_EN
        , .op_count()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a;
            3'd2: return ~(a | b);
            3'd3: return a | b;
            3'd4: return a & b;
            3'd5: return ~(a & b);
            3'd6: return ~(a ^ b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the main instance; scoreboard tracks accepts and transfers seen before the edge.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic rdy);
        logic acc, xfer;
        logic [10:0] e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        @(negedge clk);
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL stale_result: observed y=%0h with no beat outstanding, expected no transfer", out_y);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_y", 32'(out_y), 32'(e[7:0]));
                check("sb_op", 32'(out_op), 32'(e[10:8]));
                n_xfer++;
            end
        end
        if (acc) exp_q.push_back({op, ref_op(op, a, b)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tt_exp [8];
        logic [7:0] held_y;
        logic [2:0] held_op;
        int first_v, last_v, nvalid, x0;
        logic [2:0] o1;
        logic [7:0] a1, b1;

        tt_exp = '{8'h0F, 8'hF0, 8'h03, 8'hFC, 8'hC0, 8'h3F, 8'hC3, 8'h3C};
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
        w1_in_valid = 1'b0; w1_in_op = 3'd0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Truth table: a=F0, b=CC, ops 0..7 back to back
        for (int k = 0; k < 12; k++) begin
            if (k < 8) cycle(1'b1, 3'(k), 8'hF0, 8'hCC, 1'b1);
            else       cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
            if (k < 3 || k == 11) begin
                check("tt_valid_low", 32'(out_valid), 32'd0);
            end else begin
                check("tt_valid", 32'(out_valid), 32'd1);
                check("tt_y", 32'(out_y), 32'(tt_exp[k-3]));
                check("tt_op", 32'(out_op), 32'(k-3));
            end
        end

        // Latency/throughput: 10 back-to-back beats
        first_v = -1; last_v = -1; nvalid = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(k < 10, 3'(k), 8'(k * 37 + 1), 8'(k * 11 + 5), 1'b1);
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        check("lat_first_valid", 32'(first_v), 32'd3);
        check("lat_last_valid", 32'(last_v), 32'd12);
        check("lat_valid_count", 32'(nvalid), 32'd10);

        // Backpressure: fill, stall 6 cycles while offering beats, then drain
        x0 = n_xfer;
        for (int k = 0; k < 4; k++) cycle(1'b1, 3'(k + 3), 8'(8'hA5 + k), 8'h3C, 1'b1);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        held_y  = out_y;
        held_op = out_op;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 3'd7, 8'(k), 8'hFF, 1'b0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_y", 32'(out_y), 32'(held_y));
            check("bp_hold_op", 32'(out_op), 32'(held_op));
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        check("bp_xfer_count", 32'(n_xfer - x0), 32'd4);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with 3 beats in flight
        for (int k = 0; k < 3; k++) cycle(1'b1, 3'(k + 5), 8'h5A, 8'h96, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_y", 32'(out_y), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
            if (out_valid) nvalid++;
        end
        check("mid_rst_no_stale", 32'(nvalid), 32'd0);

        // Single-bit corner: all (a,b) pairs x 8 ops on the WIDTH=1 instance
        for (int i = 0; i < 36; i++) begin
            w1_in_valid = (i < 32);
            w1_in_op    = 3'(i >> 2);
            w1_in_a     = 1'(i >> 1);
            w1_in_b     = 1'(i);
            @(posedge clk);
            #1;
            if (i >= 3 && i < 35) begin
                o1 = 3'((i - 3) >> 2);
                a1 = {7'd0, 1'((i - 3) >> 1)};
                b1 = {7'd0, 1'(i - 3)};
                check("w1_valid", 32'(w1_out_valid), 32'd1);
                check("w1_y", 32'(w1_out_y), 32'(ref_op(o1, a1, b1) & 8'h01));
                check("w1_op", 32'(w1_out_op), 32'(o1));
            end
        end
        w1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("w1_idle", 32'(w1_out_valid), 32'd0);

`ifdef NOR_LU_STATS_EN
        // Stats: 17 completed results wrap a 4-bit counter to 1
        rst_n = 1'b0;
        #1;
        check("stats_rst", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        x0 = n_xfer;
        for (int k = 0; k < 17; k++) cycle(1'b1, 3'(k), 8'(k), 8'(k * 3), 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        check("stats_xfers", 32'(n_xfer - x0), 32'd17);
        check("stats_wrap", 32'(op_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
